// File: rtl/uart_pkg.sv
// uart_pkg: shared receive-entry struct, trigger-level enum and timeout constants
package uart_pkg;
  typedef struct packed {
    logic       bi;
    logic       fe;
    logic       pe;
    logic [7:0] data;
  } rx_entry_t;
  typedef enum logic [1:0] {TRIG_1, TRIG_4, TRIG_8, TRIG_14} trig_lvl_e;
  localparam int CTO_CHARS = 4;
  localparam int BRC_PER_BIT = 16;
  function automatic int trig_entries(trig_lvl_e t);
    return t == TRIG_1 ? 1 : t == TRIG_4 ? 4 : t == TRIG_8 ? 8 : 14;
  endfunction
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: FWFT sync FIFO with runtime capacity cap; push/pop/flush in, rdata/full/empty/count/pushed/popped out
module uart_sync_fifo #(
  parameter int W = 11,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CW-1:0] cap,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic          pushed,
  output logic          popped,
  output logic [CW-1:0] count
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q;
  assign empty  = count_q == '0;
  assign full   = count_q >= cap;
  assign popped = pop & !empty & !flush;
  // a pop in the same cycle frees the slot, so a full FIFO still accepts the push
  assign pushed = push & !flush & (!full | popped);
  assign rdata  = empty ? '0 : mem_q[rptr_q];
  assign count  = count_q;
  always_ff @(posedge clk)
    if (pushed) mem_q[wptr_q] <= wdata;
  always_ff @(posedge clk)
    if (rst | flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_q + AW'(pushed);
      rptr_q  <= rptr_q + AW'(popped);
      count_q <= count_q + CW'(pushed) - CW'(popped);
    end
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receive FIFO with line-status bits, trigger-level and character-timeout interrupts
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          brcx16,
  input  int            num_bits,
  input  logic          parity_en,
  input  logic          d_rdy,
  input  logic [7:0]    d,
  input  logic          parity_er,
  input  logic          frame_er,
  input  logic          break_itr,
  input  logic          fifo_en,
  input  logic          fifo_clr,
  input  logic [1:0]    trig_lvl,
  input  logic          rd,
  input  logic          lsr_rd,
  output logic [7:0]    dout,
  output logic          dout_pe,
  output logic          dout_fe,
  output logic          dout_bi,
  output logic          dr,
  output logic          oe,
  output logic          fifo_err,
  output logic          rda_itr,
  output logic          cto_itr,
  output logic [CW-1:0] count
);
  rx_entry_t     wentry, head;
  logic          d_rdy_q, fifo_en_q, oe_q, oe_d, cto_q, cto_d;
  logic          push, flush, full, empty, pushed, popped, evt, active;
  logic [CW-1:0] err_cnt_q, err_cnt_d;
  logic [9:0]    cto_cnt_q, cto_cnt_d, limit;
  assign push   = d_rdy & !d_rdy_q;
  assign flush  = fifo_clr | (fifo_en != fifo_en_q);
  assign wentry = '{bi: break_itr, fe: frame_er, pe: parity_er, data: d};
  uart_sync_fifo #(.W($bits(rx_entry_t)), .DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .cap    (fifo_en ? CW'(DEPTH) : CW'(1)),
    .push   (push),
    .pop    (rd),
    .flush  (flush),
    .wdata  (wentry),
    .rdata  (head),
    .full   (full),
    .empty  (empty),
    .pushed (pushed),
    .popped (popped),
    .count  (count)
  );
  assign limit  = 10'(CTO_CHARS * BRC_PER_BIT * (num_bits + 2 + int'(parity_en)));
  assign evt    = pushed | popped | flush;
  assign active = fifo_en & !empty;
  always_comb begin
    oe_d      = (push & full & !popped & !flush) | (oe_q & !lsr_rd);
    // erroneous-entry counter: fifo_err falls exactly when the last flagged entry leaves
    err_cnt_d = flush ? '0 : err_cnt_q + CW'(pushed & (break_itr | frame_er | parity_er))
                                       - CW'(popped & (head.bi | head.fe | head.pe));
    cto_cnt_d = (evt | !active) ? '0 : (brcx16 && cto_cnt_q != limit) ? cto_cnt_q + 10'd1 : cto_cnt_q;
    cto_d     = (evt | !fifo_en) ? 1'b0 : cto_q | (active && cto_cnt_d == limit);
  end
  always_ff @(posedge clk)
    if (rst) begin
      d_rdy_q   <= 1'b0;
      fifo_en_q <= 1'b0;
      oe_q      <= 1'b0;
      err_cnt_q <= '0;
      cto_cnt_q <= '0;
      cto_q     <= 1'b0;
    end else begin
      d_rdy_q   <= d_rdy;
      fifo_en_q <= fifo_en;
      oe_q      <= oe_d;
      err_cnt_q <= err_cnt_d;
      cto_cnt_q <= cto_cnt_d;
      cto_q     <= cto_d;
    end
  assign dout     = head.data;
  assign dout_pe  = head.pe;
  assign dout_fe  = head.fe;
  assign dout_bi  = head.bi;
  assign dr       = !empty;
  assign oe       = oe_q;
  assign fifo_err = err_cnt_q != '0;
  assign rda_itr  = int'(count) >= (fifo_en ? trig_entries(trig_lvl_e'(trig_lvl)) : 1);
  assign cto_itr  = cto_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed self-checking bench for uart_rx_fifo
module tb_uart_rx_fifo;
  logic       clk = 1'b0;
  logic       rst, brcx16, parity_en, d_rdy, parity_er, frame_er, break_itr;
  logic       fifo_en, fifo_clr, rd, lsr_rd;
  int         num_bits;
  logic [7:0] d, dout;
  logic [1:0] trig_lvl;
  logic       dout_pe, dout_fe, dout_bi, dr, oe, fifo_err, rda_itr, cto_itr;
  logic [4:0] count;
  int         n_cmp = 0;
  int         n_err = 0;
  always #5 clk = ~clk;
  uart_rx_fifo #(.DEPTH(16)) dut (
    .clk(clk), .rst(rst), .brcx16(brcx16), .num_bits(num_bits), .parity_en(parity_en),
    .d_rdy(d_rdy), .d(d), .parity_er(parity_er), .frame_er(frame_er), .break_itr(break_itr),
    .fifo_en(fifo_en), .fifo_clr(fifo_clr), .trig_lvl(trig_lvl), .rd(rd), .lsr_rd(lsr_rd),
    .dout(dout), .dout_pe(dout_pe), .dout_fe(dout_fe), .dout_bi(dout_bi), .dr(dr), .oe(oe),
    .fifo_err(fifo_err), .rda_itr(rda_itr), .cto_itr(cto_itr), .count(count)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [7:0] v, input logic fe);
    d = v;
    frame_er = fe;
    d_rdy = 1'b1;
    tick();
    d_rdy = 1'b0;
    frame_er = 1'b0;
    tick();
  endtask
  task automatic pop();
    rd = 1'b1;
    tick();
    rd = 1'b0;
  endtask
  task automatic clr();
    fifo_clr = 1'b1;
    tick();
    fifo_clr = 1'b0;
  endtask
  initial begin
    rst = 1'b1; brcx16 = 1'b0; num_bits = 8; parity_en = 1'b0; d_rdy = 1'b0; d = '0;
    parity_er = 1'b0; frame_er = 1'b0; break_itr = 1'b0; fifo_en = 1'b1; fifo_clr = 1'b0;
    trig_lvl = 2'b00; rd = 1'b0; lsr_rd = 1'b0;
    tick(); tick();
    chk("rst_count", count, 0);
    chk("rst_dr", dr, 0);
    chk("rst_oe", oe, 0);
    chk("rst_dout", dout, 0);
    chk("rst_rda", rda_itr, 0);
    chk("rst_cto", cto_itr, 0);
    chk("rst_ferr", fifo_err, 0);
    rst = 1'b0;
    tick(); tick();
    push(8'h41, 0); push(8'h42, 0); push(8'h43, 0);
    chk("ord_count", count, 3);
    chk("ord_d0", dout, 8'h41);
    pop();
    chk("ord_d1", dout, 8'h42);
    pop();
    chk("ord_d2", dout, 8'h43);
    chk("ord_dr", dr, 1);
    pop();
    chk("ord_dr_low", dr, 0);
    chk("ord_dout0", dout, 0);
    pop();
    chk("empty_rd_count", count, 0);
    chk("empty_rd_oe", oe, 0);
    trig_lvl = 2'b01;
    push(8'h01, 0); push(8'h02, 0); push(8'h03, 0);
    chk("trig_3", rda_itr, 0);
    push(8'h04, 0);
    chk("trig_4", rda_itr, 1);
    pop();
    chk("trig_rd", rda_itr, 0);
    clr();
    chk("clr_count", count, 0);
    trig_lvl = 2'b00;
    for (int i = 0; i < 16; i++) push(8'(i + 1), 0);
    chk("full_count", count, 16);
    chk("full_oe", oe, 0);
    push(8'h99, 0);
    chk("ovr_oe", oe, 1);
    chk("ovr_count", count, 16);
    lsr_rd = 1'b1;
    tick();
    lsr_rd = 1'b0;
    chk("lsr_clr_oe", oe, 0);
    d = 8'hAA; d_rdy = 1'b1; rd = 1'b1;
    tick();
    d_rdy = 1'b0; rd = 1'b0;
    tick();
    chk("pp_count", count, 16);
    chk("pp_oe", oe, 0);
    for (int i = 2; i <= 16; i++) begin
      chk("drain", dout, i);
      pop();
    end
    chk("drain_last", dout, 8'hAA);
    pop();
    chk("drain_count", count, 0);
    push(8'h10, 0); push(8'h11, 0); push(8'h12, 1);
    chk("err_set", fifo_err, 1);
    chk("err_head_fe", dout_fe, 0);
    pop();
    chk("err_rd1", fifo_err, 1);
    pop();
    chk("err_rd2", fifo_err, 1);
    chk("err_head_fe2", dout_fe, 1);
    pop();
    chk("err_rd3", fifo_err, 0);
    push(8'h20, 0);
    brcx16 = 1'b1;
    for (int i = 0; i < 639; i++) tick();
    chk("cto_639", cto_itr, 0);
    tick();
    chk("cto_640", cto_itr, 1);
    tick(); tick();
    chk("cto_hold", cto_itr, 1);
    brcx16 = 1'b0;
    pop();
    chk("cto_rd", cto_itr, 0);
    num_bits = 5;
    push(8'h21, 0);
    brcx16 = 1'b1;
    for (int i = 0; i < 447; i++) tick();
    chk("cto5_447", cto_itr, 0);
    tick();
    chk("cto5_448", cto_itr, 1);
    brcx16 = 1'b0;
    clr();
    chk("cto5_clr", cto_itr, 0);
    num_bits = 8;
    d = 8'h55; d_rdy = 1'b1;
    for (int i = 0; i < 40; i++) tick();
    d_rdy = 1'b0;
    tick();
    chk("held_count", count, 1);
    clr();
    fifo_en = 1'b0;
    tick();
    push(8'h61, 0);
    chk("m0_count", count, 1);
    chk("m0_rda", rda_itr, 1);
    push(8'h62, 0);
    chk("m0_oe", oe, 1);
    chk("m0_count2", count, 1);
    chk("m0_head", dout, 8'h61);
    lsr_rd = 1'b1;
    tick();
    lsr_rd = 1'b0;
    chk("m0_lsr", oe, 0);
    d = 8'h63; d_rdy = 1'b1; lsr_rd = 1'b1;
    tick();
    d_rdy = 1'b0; lsr_rd = 1'b0;
    chk("set_wins", oe, 1);
    tick();
    fifo_en = 1'b1;
    tick();
    chk("tog_count", count, 0);
    chk("tog_oe", oe, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
